// File: rtl/pipe_reg_pkg.sv
// Purpose: shared word width and stage-occupancy encoding for pipeline boundary registers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_reg_pkg;

    // Default datapath word width for pipeline boundaries.
    localparam int WORD_W = 64;

    // Occupancy encoding; the hazard unit reads the same values from count.
    typedef enum logic [1:0] {
        PIPE_EMPTY = 2'd0,
        PIPE_ONE   = 2'd1,
        PIPE_TWO   = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/pipe_reg_dff_en.sv
// Purpose: register with synchronous reset, synchronous clear and load enable.
// Latency: 1 cycle from d to q when en=1.
// Backpressure: none; holds its value whenever en=0.
module dff_en #(
    parameter int               SIZE    = 64,
    parameter logic [SIZE-1:0]  RST_VAL = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            en,
    input  logic [SIZE-1:0] d,
    output logic [SIZE-1:0] q
);

    // Reset and clear both return the register to RST_VAL; otherwise load on enable.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_reg.sv
// Purpose: elastic pipeline stage register with valid/ready, flush and optional skid slot.
// Latency: 1 cycle from in_fire to out_valid/out_data.
// Backpressure: SKID=1 holds two entries, in_ready registered; SKID=0 holds one, in_ready combinational.
module pipe_reg
    import pipe_reg_pkg::*;
#(
    parameter int               WIDTH     = WORD_W,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               SKID      = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    pipe_state_t      state;
    pipe_state_t      state_nxt;
    logic             in_fire;
    logic             out_fire;
    logic             main_en;
    logic             main_sel_skid;
    logic             skid_en;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    assign out_valid = (state != PIPE_EMPTY);
    assign out_data  = main_q;
    assign count     = state;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // Main slot refills from the skid slot when draining TWO, otherwise from upstream.
    assign main_d = main_sel_skid ? skid_q : in_data;

    // Occupancy register; rst wins over everything, flush handled in next-state logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= PIPE_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and slot load enables. Registers only load on an accepted beat,
    // so payload on in_data while in_valid=0 never reaches out_data.
    always_comb begin
        state_nxt     = state;
        main_en       = 1'b0;
        main_sel_skid = 1'b0;
        skid_en       = 1'b0;
        case (state)
            PIPE_EMPTY: begin
                if (in_fire) begin
                    state_nxt = PIPE_ONE;
                    main_en   = 1'b1;
                end
            end
            PIPE_ONE: begin
                if (in_fire && out_fire) begin
                    main_en = 1'b1;
                end else if (in_fire) begin
                    // Only reachable with a skid slot; SKID=0 blocks in_ready here.
                    if (SKID) begin
                        state_nxt = PIPE_TWO;
                        skid_en   = 1'b1;
                    end
                end else if (out_fire) begin
                    state_nxt = PIPE_EMPTY;
                end
            end
            PIPE_TWO: begin
                if (out_fire) begin
                    state_nxt     = PIPE_ONE;
                    main_en       = 1'b1;
                    main_sel_skid = 1'b1;
                end
            end
            default: begin
                state_nxt = PIPE_EMPTY;
            end
        endcase
        // Squash: accepted input is discarded, delivered output stays delivered.
        if (flush) begin
            state_nxt = PIPE_EMPTY;
            main_en   = 1'b0;
            skid_en   = 1'b0;
        end
    end

    dff_en #(
        .SIZE    (WIDTH),
        .RST_VAL (RESET_VAL)
    ) u_main (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .en  (main_en),
        .d   (main_d),
        .q   (main_q)
    );

    generate
        if (SKID) begin : g_skid
            logic rdy_q;

            dff_en #(
                .SIZE    (WIDTH),
                .RST_VAL (RESET_VAL)
            ) u_skid (
                .clk (clk),
                .rst (rst),
                .clr (flush),
                .en  (skid_en),
                .d   (in_data),
                .q   (skid_q)
            );

            // Registered ready: tracks whether the next state leaves a free slot.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rdy_q <= 1'b1;
                end else begin
                    rdy_q <= (state_nxt != PIPE_TWO);
                end
            end

            assign in_ready = rdy_q;
        end else begin : g_noskid
            assign skid_q   = RESET_VAL;
            assign in_ready = ~out_valid | out_ready;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_reg.sv
// Purpose: directed checks of pipe_reg (SKID=1, 64-bit) plus a random sweep of the SKID=0 variant.
// Latency: n/a.
// Backpressure: n/a.
module tb_pipe_reg;
    import pipe_reg_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default parameters (SKID=1, 64-bit, reset value 0).
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [63:0] in_data, out_data;
    logic [1:0]  count;

    // Instance B: SKID=0, 32-bit, reset value all ones.
    logic        b_rst, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0] b_in_data, b_out_data;
    logic [1:0]  b_count;

    int errors = 0;
    int checks = 0;

    pipe_reg dut_a (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    pipe_reg #(
        .WIDTH     (32),
        .RESET_VAL (32'hFFFF_FFFF),
        .SKID      (1'b0)
    ) dut_b (
        .clk       (clk),
        .rst       (b_rst),
        .flush     (b_flush),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .count     (b_count)
    );

    // Advance one rising edge and step off it before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 64'hDEAD; out_ready = 1'b0;
        b_rst = 1'b1; b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0; in_valid = 1'b0; b_rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 64'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (b_out_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_b_out_data got=%h exp=ffffffff", b_out_data); end
        checks++; if (b_count !== 2'd0) begin errors++; $display("FAIL reset_b_count got=%0d exp=0", b_count); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_out_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 64'(i);
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d] got=%b exp=1", i, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_data !== 64'(i)) begin
                errors++; $display("FAIL stream_out[%0d] got=%b/%h exp=1/%h", i, out_valid, out_data, 64'(i));
            end
            checks++; if (count !== 2'd1) begin errors++; $display("FAIL stream_count[%0d] got=%0d exp=1", i, count); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0 || count !== 2'd0) begin
            errors++; $display("FAIL stream_drain got=%b/%0d exp=0/0", out_valid, count);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 64'hAAAA_0001;
        tick();
        in_data = 64'hBBBB_0002;
        tick();
        in_valid = 1'b0; in_data = 64'hCCCC_0000;
        checks++; if (count !== 2'd2) begin errors++; $display("FAIL bp_count got=%0d exp=2", count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
        checks++; if (out_data !== 64'hAAAA_0001 || out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_head got=%b/%h exp=1/aaaa0001", out_valid, out_data);
        end
        tick();
        tick();
        checks++; if (out_data !== 64'hAAAA_0001 || out_valid !== 1'b1 || count !== 2'd2) begin
            errors++; $display("FAIL bp_stall_hold got=%b/%h/%0d exp=1/aaaa0001/2", out_valid, out_data, count);
        end
        out_ready = 1'b1;
        tick();
        checks++; if (out_data !== 64'hBBBB_0002 || out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_second got=%b/%h exp=1/bbbb0002", out_valid, out_data);
        end
        checks++; if (in_ready !== 1'b1 || count !== 2'd1) begin
            errors++; $display("FAIL bp_ready_back got=%b/%0d exp=1/1", in_ready, count);
        end
        tick();
        checks++; if (out_valid !== 1'b0 || count !== 2'd0) begin
            errors++; $display("FAIL bp_empty got=%b/%0d exp=0/0", out_valid, count);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 64'h11;
        tick();
        in_data = 64'h22;
        tick();
        checks++; if (count !== 2'd2) begin errors++; $display("FAIL flush_pre_count got=%0d exp=2", count); end
        flush = 1'b1; in_valid = 1'b1; in_data = 64'h33;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || count !== 2'd0) begin
            errors++; $display("FAIL flush_empty got=%b/%0d exp=0/0", out_valid, count);
        end
        checks++; if (out_data !== 64'h0) begin errors++; $display("FAIL flush_data got=%h exp=0", out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_valid !== 1'b0 || out_data === 64'h33) begin
                errors++; $display("FAIL flush_no_ghost[%0d] got=%b/%h exp=0/not33", i, out_valid, out_data);
            end
        end
    endtask

    task automatic test_priority();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 64'h44;
        tick();
        checks++; if (count !== 2'd1) begin errors++; $display("FAIL prio_pre_count got=%0d exp=1", count); end
        rst = 1'b1; flush = 1'b1; out_ready = 1'b1; in_data = 64'h55;
        tick();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        checks++; if (count !== 2'd0 || out_valid !== 1'b0 || out_data !== 64'h0) begin
            errors++; $display("FAIL prio_empty got=%0d/%b/%h exp=0/0/0", count, out_valid, out_data);
        end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL prio_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_sweep();
        logic [31:0] exp_q[$];
        logic [31:0] next_word;
        logic [31:0] exp_w;
        int          sent;
        int          recv;
        next_word = 32'h1000_0000;
        sent = 0;
        recv = 0;
        for (int cyc = 0; cyc < 320; cyc++) begin
            b_in_valid  = (cyc < 300) ? 1'($urandom_range(0, 1)) : 1'b0;
            b_out_ready = (cyc < 300) ? 1'($urandom_range(0, 1)) : 1'b1;
            b_in_data   = b_in_valid ? next_word : 32'hxxxx_xxxx;
            #1;
            checks++; if (b_in_ready !== (~b_out_valid | b_out_ready)) begin
                errors++; $display("FAIL sweep_ready[%0d] got=%b exp=%b", cyc, b_in_ready, ~b_out_valid | b_out_ready);
            end
            if (b_out_valid && b_out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL sweep_spurious[%0d] got=%h exp=none", cyc, b_out_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (b_out_data !== exp_w) begin
                        errors++; $display("FAIL sweep_data[%0d] got=%h exp=%h", cyc, b_out_data, exp_w);
                    end
                end
                recv++;
            end
            if (b_in_valid && b_in_ready) begin
                exp_q.push_back(next_word);
                next_word = next_word + 32'd1;
                sent++;
            end
            tick();
        end
        checks++; if (recv !== sent || exp_q.size() != 0 || sent == 0) begin
            errors++; $display("FAIL sweep_totals got=%0d exp=%0d left=%0d", recv, sent, exp_q.size());
        end
        b_in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_priority();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
